// File: rtl/processor_flow_ctrl_pkg.sv
// rtl/processor_flow_ctrl_pkg.sv - shared state encoding and defaults for the flow controller
package processor_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FAULT = 2'd2
  } flow_state_t;

  localparam int DEFAULT_STACK_DEPTH = 8;

endpackage

// File: rtl/processor_flow_ctrl_ret_stack.sv
// rtl/processor_flow_ctrl_ret_stack.sv - return-address LIFO with occupancy count
module processor_ret_stack
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] ONE = 1;
  localparam logic [DW-1:0] MAX = DW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_m1;

  assign depth_m1 = depth_q - ONE;
  assign full     = (depth_q == MAX);
  assign empty    = (depth_q == '0);
  assign depth    = depth_q;
  // The empty case reads as zero so the return target never shows stale RAM.
  assign top      = empty ? '0 : mem[depth_m1[PW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push && !full) begin
      depth_q <= depth_q + ONE;
    end else if (pop && !empty) begin
      depth_q <= depth_m1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push && !full) begin
      mem[depth_q[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/processor_flow_ctrl.sv
// rtl/processor_flow_ctrl.sv - call/jump/return redirect control with stall and fault handling
module processor_flow_ctrl
  import processor_flow_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE   = 18,
  parameter int WORD_SIZE   = 18,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic                           dec_is_call,
  input  logic                           dec_is_jump,
  input  logic                           dec_is_return,
  input  logic                           cond_true,
  input  logic [WORD_SIZE-1:0]           dec_target,
  input  logic [ADDR_SIZE-1:0]           dec_ip_plus_one,
  input  logic                           stall_req,
  output logic                           no_operation,
  output logic [WORD_SIZE-1:0]           ip_to_call,
  output logic                           call_performed,
  output logic [WORD_SIZE-1:0]           ip_to_return,
  output logic                           return_performed,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           fault
);

  flow_state_t          state, next_state;
  logic                 push, pop, full, empty;
  logic [ADDR_SIZE-1:0] top;

  processor_ret_stack #(
    .WIDTH(ADDR_SIZE),
    .DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (dec_ip_plus_one),
    .top       (top),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  assign ip_to_return = WORD_SIZE'(top);
  assign ip_to_call   = call_performed ? dec_target : '0;
  assign fault        = (state == ST_FAULT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // STALL with stall_req low acts on the held decode slot directly, so the
  // redirect lands in the first cycle the hazard clears and state drops to RUN.
  always_comb begin
    next_state       = state;
    no_operation     = 1'b0;
    call_performed   = 1'b0;
    return_performed = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    if (!reset) begin
      case (state)
        ST_FAULT: begin
          no_operation = 1'b1;
        end
        default: begin
          if (stall_req) begin
            no_operation = 1'b1;
            next_state   = ST_STALL;
          end else begin
            next_state = ST_RUN;
            if (dec_valid) begin
              if (dec_is_return) begin
                if (empty) begin
                  next_state = ST_FAULT;
                end else begin
                  return_performed = 1'b1;
                  pop              = 1'b1;
                end
              end else if (dec_is_call) begin
                if (full) begin
                  next_state = ST_FAULT;
                end else begin
                  call_performed = 1'b1;
                  push           = 1'b1;
                end
              end else if (dec_is_jump && cond_true) begin
                call_performed = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_processor_flow_ctrl.sv
// tb/tb_processor_flow_ctrl.sv - randomized self-checking bench against a queue-based model
module tb_processor_flow_ctrl;

  localparam int AW = 18;
  localparam int WW = 18;
  localparam int SD = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          dec_valid, dec_is_call, dec_is_jump, dec_is_return, cond_true;
  logic [WW-1:0] dec_target;
  logic [AW-1:0] dec_ip_plus_one;
  logic          stall_req;
  logic          no_operation, call_performed, return_performed, fault;
  logic [WW-1:0] ip_to_call, ip_to_return;
  logic [3:0]    depth;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] m_stack [$];
  bit            m_fault = 1'b0;

  processor_flow_ctrl #(
    .ADDR_SIZE(AW),
    .WORD_SIZE(WW),
    .STACK_DEPTH(SD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dec_valid        (dec_valid),
    .dec_is_call      (dec_is_call),
    .dec_is_jump      (dec_is_jump),
    .dec_is_return    (dec_is_return),
    .cond_true        (cond_true),
    .dec_target       (dec_target),
    .dec_ip_plus_one  (dec_ip_plus_one),
    .stall_req        (stall_req),
    .no_operation     (no_operation),
    .ip_to_call       (ip_to_call),
    .call_performed   (call_performed),
    .ip_to_return     (ip_to_return),
    .return_performed (return_performed),
    .depth            (depth),
    .fault            (fault)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare combinational outputs mid-cycle, then advance.
  task automatic drive_cycle(input bit rst, input bit v, input bit c, input bit j, input bit r,
                             input bit ct, input logic [WW-1:0] tgt, input logic [AW-1:0] ipp,
                             input bit stl);
    bit            e_nop, e_call, e_ret, go_fault, do_push, do_pop;
    logic [WW-1:0] e_ipc, e_ipr;
    reset = rst; dec_valid = v; dec_is_call = c; dec_is_jump = j; dec_is_return = r;
    cond_true = ct; dec_target = tgt; dec_ip_plus_one = ipp; stall_req = stl;
    e_nop = 0; e_call = 0; e_ret = 0; go_fault = 0; do_push = 0; do_pop = 0;
    e_ipc = '0;
    e_ipr = (m_stack.size() > 0) ? WW'(m_stack[$]) : '0;
    if (!rst) begin
      if (m_fault || stl) begin
        e_nop = 1;
      end else if (v && r) begin
        if (m_stack.size() == 0) go_fault = 1;
        else begin e_ret = 1; do_pop = 1; end
      end else if (v && c) begin
        if (m_stack.size() == SD) go_fault = 1;
        else begin e_call = 1; e_ipc = tgt; do_push = 1; end
      end else if (v && j && ct) begin
        e_call = 1; e_ipc = tgt;
      end
    end
    @(negedge clock);
    check_val("no_operation", 32'(no_operation), 32'(e_nop));
    check_val("call_performed", 32'(call_performed), 32'(e_call));
    if (e_call) check_val("ip_to_call", 32'(ip_to_call), 32'(e_ipc));
    check_val("return_performed", 32'(return_performed), 32'(e_ret));
    check_val("ip_to_return", 32'(ip_to_return), 32'(e_ipr));
    check_val("depth", 32'(depth), 32'(m_stack.size()));
    check_val("fault", 32'(fault), 32'(m_fault));
    if (rst) begin
      m_stack.delete();
      m_fault = 0;
    end else begin
      if (go_fault) m_fault = 1;
      if (do_push) m_stack.push_back(ipp);
      if (do_pop) void'(m_stack.pop_back());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive_cycle(1, 0, 0, 0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_reset();
    check_val("reset_depth", 32'(depth), 32'd0);
    check_val("reset_fault", 32'(fault), 32'd0);

    // basic call then return
    drive_cycle(0, 1, 1, 0, 0, 1, 18'h00100, 18'h00011, 0);
    check_val("call_depth", 32'(depth), 32'd1);
    drive_cycle(0, 0, 0, 0, 0, 0, '0, '0, 0);
    drive_cycle(0, 1, 0, 0, 1, 0, '0, '0, 0);
    check_val("ret_depth", 32'(depth), 32'd0);

    // overflow on ninth call, fault sticks
    for (int i = 0; i < 9; i++)
      drive_cycle(0, 1, 1, 0, 0, 1, WW'(18'h00200 + i), AW'(18'h00300 + i), 0);
    check_val("ovf_fault", 32'(fault), 32'd1);
    check_val("ovf_depth", 32'(depth), 32'd8);
    for (int i = 0; i < 3; i++)
      drive_cycle(0, 1, 0, 0, 1, 0, '0, '0, 0);
    do_reset();

    // underflow
    drive_cycle(0, 1, 0, 0, 1, 0, '0, '0, 0);
    check_val("unf_fault", 32'(fault), 32'd1);
    drive_cycle(0, 1, 1, 0, 0, 1, 18'h00123, 18'h00007, 0);
    do_reset();
    check_val("unf_reset_fault", 32'(fault), 32'd0);
    check_val("unf_reset_depth", 32'(depth), 32'd0);

    // stall for three cycles with a call held, redirect on the fourth
    for (int i = 0; i < 3; i++)
      drive_cycle(0, 1, 1, 0, 0, 1, 18'h00400, 18'h00021, 1);
    drive_cycle(0, 1, 1, 0, 0, 1, 18'h00400, 18'h00021, 0);
    check_val("stall_depth", 32'(depth), 32'd1);
    do_reset();

    // jumps: not taken, then taken to the top of the address range
    drive_cycle(0, 1, 0, 1, 0, 0, 18'h3FFFF, 18'h00001, 0);
    drive_cycle(0, 1, 0, 1, 0, 1, 18'h3FFFF, 18'h00001, 0);
    check_val("jump_depth", 32'(depth), 32'd0);

    // call and return together: return wins
    drive_cycle(0, 1, 1, 0, 0, 1, 18'h00500, 18'h00040, 0);
    drive_cycle(0, 1, 1, 0, 0, 1, 18'h00600, 18'h00050, 0);
    drive_cycle(0, 1, 1, 0, 1, 1, 18'h00700, 18'h00060, 0);
    check_val("both_depth", 32'(depth), 32'd1);
    check_val("both_top", 32'(ip_to_return), 32'h00040);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      drive_cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 1) == 1,
                  WW'($urandom),
                  AW'($urandom),
                  $urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/processor_flow_ctrl.md
PROCESSOR_FLOW_CTRL -- requirements
Module: processor_flow_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 18, code address width.
REQ-002 SHALL have parameter WORD_SIZE, default 18, data/target word width.
REQ-003 SHALL have parameter STACK_DEPTH, default 8, return-stack entries (power of two, >=2).
REQ-004 SHALL have port: clock  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: dec_valid  input  1  decode slot holds a real instruction.
REQ-007 SHALL have port: dec_is_call  input  1  instruction is a call.
REQ-008 SHALL have port: dec_is_jump  input  1  instruction is a conditional/unconditional jump.
REQ-009 SHALL have port: dec_is_return  input  1  instruction is a return.
REQ-010 SHALL have port: cond_true  input  1  jump condition satisfied (tie 1 for unconditional).
REQ-011 SHALL have port: dec_target  input  WORD_SIZE  call/jump destination.
REQ-012 SHALL have port: dec_ip_plus_one  input  ADDR_SIZE  return address of the decoded instruction.
REQ-013 SHALL have port: stall_req  input  1  downstream hazard; freeze fetch.
REQ-014 SHALL have port: no_operation  output  1  fetch-stage freeze.
REQ-015 SHALL have port: ip_to_call  output  WORD_SIZE  redirect target for call/jump.
REQ-016 SHALL have port: call_performed  output  1  call/jump redirect this cycle.
REQ-017 SHALL have port: ip_to_return  output  WORD_SIZE  top-of-stack return target, zero-extended.
REQ-018 SHALL have port: return_performed  output  1  return redirect this cycle.
REQ-019 SHALL have port: depth  output  $clog2(STACK_DEPTH)+1  current stack occupancy.
REQ-020 SHALL have port: fault  output  1  sticky overflow/underflow flag.

Function
REQ-021 SHALL implement FSM states RUN, STALL, FAULT; redirect outputs combinational from inputs and current state/stack.
REQ-022 In RUN with stall_req=1: SHALL go to STALL, assert no_operation, suppress both redirects, leave stack unchanged.
REQ-023 In STALL: SHALL hold no_operation=1, suppress redirects, return to RUN the cycle after stall_req falls; decode inputs are held by upstream.
REQ-024 In RUN, stall_req=0, dec_valid=1: priority return > call > jump; dec_valid=0 SHALL produce no redirect and no stack change.
REQ-025 Return with depth>0: return_performed=1, ip_to_return=top entry, pop at clock edge.
REQ-026 Call with depth<STACK_DEPTH: call_performed=1, ip_to_call=dec_target, push dec_ip_plus_one at clock edge.
REQ-027 Jump with cond_true=1: call_performed=1, ip_to_call=dec_target, no push; cond_true=0: no redirect.
REQ-028 Return with depth=0 (underflow) or call with depth=STACK_DEPTH (overflow): no redirect, no stack change, enter FAULT.
REQ-029 In FAULT: no_operation=1, redirects 0, fault=1, stack frozen; exit only via reset.
REQ-030 Call and return both set: return SHALL win, call ignored.
REQ-031 ip_to_return SHALL be 0 when depth=0; depth increments/decrements by exactly 1, never wraps.

Reset
REQ-032 reset SHALL, at the clock edge, force state RUN, depth=0, fault=0; no_operation, call_performed, return_performed SHALL read 0 when reset is high.
REQ-033 Reset mid-STALL or mid-FAULT SHALL discard all stack contents; stack RAM values need not be cleared.

Structure
REQ-034 Shared package SHALL hold state encoding (RUN/STALL/FAULT) and default STACK_DEPTH.
REQ-035 LIFO storage, pointer and depth SHALL be sub-module processor_ret_stack (push, pop, top, depth, full, empty).
REQ-036 Estimated RTL size 150-300 lines total.

Verification
REQ-037 Call dec_target=0x00100, dec_ip_plus_one=0x00011 -> call_performed=1, ip_to_call=0x00100, depth 0->1; later return -> return_performed=1, ip_to_return=0x00011, depth->0.
REQ-038 Nine calls with STACK_DEPTH=8 -> first eight redirect, ninth no redirect, fault=1, no_operation=1 held until reset.
REQ-039 Return with depth=0 -> no return_performed, FAULT; reset -> fault=0, depth=0, RUN.
REQ-040 stall_req=1 for 3 cycles while call decoded -> no_operation=1 for 3 cycles, no redirect, depth unchanged; call redirects on 4th cycle.
REQ-041 Jump cond_true=0 -> no redirect; cond_true=1, dec_target=0x3FFFF -> call_performed=1, ip_to_call=0x3FFFF, depth unchanged.
REQ-042 Call+return set with depth=2, top=0x00050 -> return_performed=1, ip_to_return=0x00050, call_performed=0, depth->1.
